trap_ctrl: RTL and testbench

//  Machine-mode trap sequencer between the interrupt sources, the pipeline and the CSR file.
//  - Arbitrates the software, timer and external interrupts and handshakes a pipeline flush.
//  - Commits trap-entry CSR updates (mepc, mcause, mstatus) and emits the handler redirect.
//  - Sequences mret: restores mstatus and redirects to mepc. No nesting; one trap in flight.

---
 rtl/trap_ctrl_pkg.sv | 40 ++++
 rtl/trap_ctrl_irq_sync.sv | 24 ++
 rtl/trap_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states, cause codes,
// mstatus bit positions, mtvec modes and the interrupt priority arbiter.
package trap_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        COMMIT  = 3'd2,
        HANDLER = 3'd3,
        RET     = 3'd4
    } trap_state_e;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Fixed priority MEI > MSI > MTI; callers qualify with "any eligible".
    function automatic logic [3:0] arb_cause(input logic ext, input logic sw, input logic tim);
        logic [3:0] cause;
        if (ext) begin
            cause = CAUSE_MEI;
        end else if (sw) begin
            cause = CAUSE_MSI;
        end else if (tim) begin
            cause = CAUSE_MTI;
        end else begin
            cause = 4'd0;
        end
        return cause;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop level synchronizer bringing the asynchronous external interrupt into clk.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; only the last stage is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: interrupt arbitration, flush handshake, trap-entry CSR
// commit and mret sequencing. All outputs are registered.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    input  logic            is_mret_i,
    input  logic            flush_ack_i,
    output logic            flush_req_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            mepc_we_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mcause_we_o,
    output logic [XLEN-1:0] mcause_o,
    output logic            mstatus_we_o,
    output logic [XLEN-1:0] mstatus_o,
    output logic [XLEN-1:0] mip_o,
    output logic            in_trap_o
);

    trap_state_e     state_q, state_d;
    logic [3:0]      cause_q, cause_d;
    logic [XLEN-1:0] mip_q, mip_d;
    logic            irq_ext_sync_s;
    logic [XLEN-1:0] elig_s;
    logic            elig_any_s;
    logic [3:0]      elig_cause_s;
    logic [XLEN-1:0] base_s, trap_tgt_s;
    logic            commit_go_s, ret_go_s;
    logic            unused_s;

    logic            flush_req_q, flush_req_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            mepc_we_q, mepc_we_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic            mcause_we_q, mcause_we_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic            mstatus_we_q, mstatus_we_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic            in_trap_q, in_trap_d;

    irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (irq_ext_i),
        .q_o   (irq_ext_sync_s)
    );

    assign unused_s = ^{pc_i[1:0], mepc_i[1:0]};

    // Pending-bit image; only MSIP/MTIP/MEIP positions can ever be set.
    always_comb begin
        mip_d     = '0;
        mip_d[3]  = irq_sw_i;
        mip_d[7]  = irq_timer_i;
        mip_d[11] = irq_ext_sync_s;
    end

    assign elig_s       = mip_q & mie_i & {XLEN{mstatus_i[MSTATUS_MIE]}};
    assign elig_any_s   = |elig_s;
    assign elig_cause_s = arb_cause(elig_s[11], elig_s[3], elig_s[7]);
    assign base_s       = {mtvec_i[XLEN-1:2], 2'b00};
    assign trap_tgt_s   = (mtvec_i[1:0] == MTVEC_VECTORED)
                        ? base_s + {{(XLEN-6){1'b0}}, cause_q, 2'b00}
                        : base_s;

    // Next-state logic; the cause is latched once and never re-arbitrated.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        commit_go_s = 1'b0;
        ret_go_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mret_i) begin
                    state_d  = RET;
                    ret_go_s = 1'b1;
                end else if (elig_any_s && pc_valid_i) begin
                    state_d = FLUSH;
                    cause_d = elig_cause_s;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (flush_ack_i) begin
                    state_d     = COMMIT;
                    commit_go_s = 1'b1;
                end else begin
                    state_d = FLUSH;
                end
            end
            COMMIT:  state_d = HANDLER;
            HANDLER: begin
                if (is_mret_i) begin
                    state_d  = RET;
                    ret_go_s = 1'b1;
                end else begin
                    state_d = HANDLER;
                end
            end
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values are prepared on the transition so they appear in the COMMIT/RET cycle.
    always_comb begin
        flush_req_d   = (state_d == FLUSH) || (state_d == COMMIT);
        redirect_d    = commit_go_s || ret_go_s;
        mepc_we_d     = commit_go_s;
        mcause_we_d   = commit_go_s;
        mstatus_we_d  = commit_go_s || ret_go_s;
        redirect_pc_d = '0;
        mepc_d        = '0;
        mcause_d      = '0;
        mstatus_d     = '0;
        if (commit_go_s) begin
            redirect_pc_d = trap_tgt_s;
            mepc_d        = {pc_i[XLEN-1:2], 2'b00};
            mcause_d      = {1'b1, {(XLEN-5){1'b0}}, cause_q};
            mstatus_d     = mstatus_i;
            mstatus_d[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]  = 1'b0;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else if (ret_go_s) begin
            redirect_pc_d = {mepc_i[XLEN-1:2], 2'b00};
            mstatus_d     = mstatus_i;
            mstatus_d[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE] = 1'b1;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else begin
            redirect_pc_d = '0;
        end
        if (commit_go_s) begin
            in_trap_d = 1'b1;
        end else if (state_d == IDLE) begin
            in_trap_d = 1'b0;
        end else begin
            in_trap_d = in_trap_q;
        end
    end

    // State and output registers; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cause_q       <= 4'd0;
            mip_q         <= '0;
            flush_req_q   <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            mepc_we_q     <= 1'b0;
            mepc_q        <= '0;
            mcause_we_q   <= 1'b0;
            mcause_q      <= '0;
            mstatus_we_q  <= 1'b0;
            mstatus_q     <= '0;
            in_trap_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            mip_q         <= mip_d;
            flush_req_q   <= flush_req_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            mepc_we_q     <= mepc_we_d;
            mepc_q        <= mepc_d;
            mcause_we_q   <= mcause_we_d;
            mcause_q      <= mcause_d;
            mstatus_we_q  <= mstatus_we_d;
            mstatus_q     <= mstatus_d;
            in_trap_q     <= in_trap_d;
        end
    end

    assign flush_req_o   = flush_req_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign mepc_we_o     = mepc_we_q;
    assign mepc_o        = mepc_q;
    assign mcause_we_o   = mcause_we_q;
    assign mcause_o      = mcause_q;
    assign mstatus_we_o  = mstatus_we_q;
    assign mstatus_o     = mstatus_q;
    assign mip_o         = mip_q;
    assign in_trap_o     = in_trap_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized trap/mret rounds
// checked against a transaction-level model of the trap rules.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq_sw_i, irq_timer_i, irq_ext_i;
    logic [31:0] mie_i, mstatus_i, mtvec_i, mepc_i, pc_i;
    logic        pc_valid_i, is_mret_i, flush_ack_i;
    logic        flush_req_o, redirect_o, mepc_we_o, mcause_we_o, mstatus_we_o, in_trap_o;
    logic [31:0] redirect_pc_o, mepc_o, mcause_o, mstatus_o, mip_o;

    int n_vec = 0;
    int n_err = 0;

    trap_ctrl #(.SYNC_STAGES(2), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
        .mie_i(mie_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .pc_i(pc_i), .pc_valid_i(pc_valid_i), .is_mret_i(is_mret_i), .flush_ack_i(flush_ack_i),
        .flush_req_o(flush_req_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .mepc_we_o(mepc_we_o), .mepc_o(mepc_o), .mcause_we_o(mcause_we_o), .mcause_o(mcause_o),
        .mstatus_we_o(mstatus_we_o), .mstatus_o(mstatus_o), .mip_o(mip_o), .in_trap_o(in_trap_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference rules, written directly from the architectural description.
    function automatic int exp_cause(input bit ext, input bit sw, input bit tim,
                                     input logic [31:0] mie, input logic gie);
        if (!gie) return -1;
        if (ext && mie[11]) return 11;
        if (sw && mie[3]) return 3;
        if (tim && mie[7]) return 7;
        return -1;
    endfunction

    function automatic logic [31:0] entry_ms(input logic [31:0] ms);
        return (ms & ~32'h0000_1888) | (ms[3] ? 32'h0000_0080 : 32'h0) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] ret_ms(input logic [31:0] ms);
        return (ms & ~32'h0000_1888) | (ms[7] ? 32'h0000_0008 : 32'h0) | 32'h0000_1880;
    endfunction

    function automatic logic [31:0] trap_target(input logic [31:0] tv, input int cause);
        logic [31:0] base;
        base = tv & ~32'h3;
        if ((tv & 32'h3) == 32'h1) return base + 32'(cause * 4);
        return base;
    endfunction

    function automatic logic [31:0] all_outs();
        return {31'h0, flush_req_o | redirect_o | mepc_we_o | mcause_we_o | mstatus_we_o
                | in_trap_o | (|redirect_pc_o) | (|mepc_o) | (|mcause_o) | (|mstatus_o) | (|mip_o)};
    endfunction

    task automatic wait_flush();
        int waited = 0;
        while (!flush_req_o && waited < 12) begin
            tick();
            waited++;
        end
        check_eq("flush_req_rise", {31'h0, flush_req_o}, 32'h1);
    endtask

    // Drives a full trap entry once flush is requested, acting as pipeline and CSR file.
    task automatic take_trap(input logic [31:0] pc, input int ack_dly, input int cause,
                             input bit drop_ext);
        logic [31:0] ms_exp, tgt;
        wait_flush();
        if (drop_ext) irq_ext_i = 1'b0;
        ms_exp = entry_ms(mstatus_i);
        tgt    = trap_target(mtvec_i, cause);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            check_eq("flush_hold", {30'h0, redirect_o, flush_req_o}, 32'h1);
        end
        flush_ack_i = 1'b1;
        pc_i        = pc;
        tick();
        flush_ack_i = 1'b0;
        pc_i        = $urandom;
        check_eq("commit_strobes", {26'h0, flush_req_o, redirect_o, mepc_we_o, mcause_we_o,
                                    mstatus_we_o, in_trap_o}, 32'h3F);
        check_eq("commit_redirect_pc", redirect_pc_o, tgt);
        check_eq("commit_mepc", mepc_o, pc & ~32'h3);
        check_eq("commit_mcause", mcause_o, 32'h8000_0000 | 32'(cause));
        check_eq("commit_mstatus", mstatus_o, ms_exp);
        mstatus_i = ms_exp;
        mepc_i    = pc & ~32'h3;
        tick();
        check_eq("handler_strobes", {26'h0, flush_req_o, redirect_o, mepc_we_o, mcause_we_o,
                                     mstatus_we_o, in_trap_o}, 32'h1);
    endtask

    task automatic do_mret();
        logic [31:0] ms_exp, tgt;
        ms_exp    = ret_ms(mstatus_i);
        tgt       = mepc_i & ~32'h3;
        is_mret_i = 1'b1;
        tick();
        is_mret_i = 1'b0;
        check_eq("ret_strobes", {27'h0, flush_req_o, redirect_o, mepc_we_o, mcause_we_o,
                                 mstatus_we_o}, 32'h9);
        check_eq("ret_redirect_pc", redirect_pc_o, tgt);
        check_eq("ret_mstatus", mstatus_o, ms_exp);
        mstatus_i = ms_exp;
        tick();
        check_eq("after_ret", {29'h0, redirect_o, mstatus_we_o, in_trap_o}, 32'h0);
    endtask

    initial begin
        bit ext, sw, tim;
        int c;
        logic [31:0] pc;

        rst_n = 1'b0;
        irq_sw_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
        mie_i = 32'h0; mstatus_i = 32'h0; mtvec_i = 32'h0; mepc_i = 32'h0; pc_i = 32'h0;
        pc_valid_i = 1'b0; is_mret_i = 1'b0; flush_ack_i = 1'b0;
        repeat (3) tick();
        check_eq("reset_outputs", all_outs(), 32'h0);
        rst_n = 1'b1;
        tick();
        check_eq("post_reset_outputs", all_outs(), 32'h0);

        // 1: direct-mode timer trap with ack after 3 cycles.
        mtvec_i = 32'h100; mie_i = 32'h80; mstatus_i = 32'h8; pc_valid_i = 1'b1;
        irq_timer_i = 1'b1;
        tick();
        check_eq("t1_mip", mip_o, 32'h80);
        check_eq("t1_no_flush_yet", {31'h0, flush_req_o}, 32'h0);
        tick();
        check_eq("t1_flush_latency", {31'h0, flush_req_o}, 32'h1);
        take_trap(32'h40, 3, 7, 1'b0);

        // 3: mret back to 0x40, then the still-pending timer is retaken.
        do_mret();
        check_eq("t3_mstatus_restored", mstatus_i & 32'h88, 32'h88);
        tick();
        check_eq("t3_retake", {31'h0, flush_req_o}, 32'h1);
        take_trap(32'h80, 0, 7, 1'b0);
        irq_timer_i = 1'b0; pc_valid_i = 1'b0;
        do_mret();

        // 2: vectored mode, all three pending; ext dropped during FLUSH.
        mtvec_i = 32'h201; mie_i = 32'h888;
        irq_sw_i = 1'b1; irq_timer_i = 1'b1; irq_ext_i = 1'b1;
        repeat (5) tick();
        check_eq("t2_mip_all", mip_o, 32'h888);
        pc_valid_i = 1'b1;
        take_trap(32'h1234, 4, 11, 1'b1);
        irq_sw_i = 1'b0; irq_timer_i = 1'b0; pc_valid_i = 1'b0;
        do_mret();
        repeat (4) tick();

        // 4: masked in three different ways; pending stays visible.
        irq_timer_i = 1'b1; mie_i = 32'h80; mstatus_i = 32'h0; pc_valid_i = 1'b1;
        repeat (3) begin tick(); check_eq("t4_gie_masked", {31'h0, flush_req_o}, 32'h0); end
        check_eq("t4_mip_visible", mip_o, 32'h80);
        mstatus_i = 32'h8; mie_i = 32'h0;
        repeat (3) begin tick(); check_eq("t4_mie_masked", {31'h0, flush_req_o}, 32'h0); end
        mie_i = 32'h80; pc_valid_i = 1'b0;
        repeat (3) begin tick(); check_eq("t4_bubble", {31'h0, flush_req_o}, 32'h0); end

        // 5: mret and an eligible irq in the same IDLE cycle.
        mepc_i = 32'h303; pc_valid_i = 1'b1; is_mret_i = 1'b1;
        tick();
        is_mret_i = 1'b0; pc_valid_i = 1'b0;
        check_eq("t5_ret_wins", {30'h0, flush_req_o, redirect_o}, 32'h1);
        check_eq("t5_ret_pc", redirect_pc_o, 32'h300);
        tick();
        check_eq("t5_no_flush", {31'h0, flush_req_o}, 32'h0);
        irq_timer_i = 1'b0; mstatus_i = 32'h8;
        repeat (2) tick();

        // 6: reset in FLUSH, then reset in COMMIT.
        irq_timer_i = 1'b1; pc_valid_i = 1'b1;
        wait_flush();
        #2 rst_n = 1'b0;
        #1 check_eq("t6_rst_in_flush", all_outs(), 32'h0);
        irq_timer_i = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) begin tick(); check_eq("t6_idle_after_flush_rst", all_outs(), 32'h0); end
        irq_timer_i = 1'b1;
        wait_flush();
        flush_ack_i = 1'b1;
        tick();
        flush_ack_i = 1'b0;
        check_eq("t6_in_commit", {31'h0, redirect_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check_eq("t6_rst_in_commit", all_outs(), 32'h0);
        irq_timer_i = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) begin tick(); check_eq("t6_idle_after_commit_rst", all_outs(), 32'h0); end

        // Randomized rounds: settle pendings with pc_valid low, then let arbitration happen.
        for (int it = 0; it < 30; it++) begin
            ext = 1'($urandom); sw = 1'($urandom); tim = 1'($urandom);
            mie_i     = $urandom;
            mstatus_i = ($urandom & ~32'h8) | (($urandom_range(0, 3) != 0) ? 32'h8 : 32'h0);
            mtvec_i   = $urandom;
            pc        = $urandom;
            pc_valid_i = 1'b0;
            irq_ext_i = ext; irq_sw_i = sw; irq_timer_i = tim;
            repeat (5) tick();
            check_eq("rnd_mip", mip_o, (ext ? 32'h800 : 32'h0) | (sw ? 32'h8 : 32'h0)
                                       | (tim ? 32'h80 : 32'h0));
            c = exp_cause(ext, sw, tim, mie_i, mstatus_i[3]);
            pc_valid_i = 1'b1;
            if (c < 0) begin
                repeat (3) begin tick(); check_eq("rnd_no_trap", {31'h0, flush_req_o}, 32'h0); end
            end else begin
                take_trap(pc, $urandom_range(0, 4), c, 1'b0);
                irq_ext_i = 1'b0; irq_sw_i = 1'b0; irq_timer_i = 1'b0; pc_valid_i = 1'b0;
                do_mret();
            end
            irq_ext_i = 1'b0; irq_sw_i = 1'b0; irq_timer_i = 1'b0; pc_valid_i = 1'b0;
            repeat (4) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
